// File: rtl/morse_pkg.sv
// Shared types for the Morse front end and decoder.
// Holds the key-state encoding and the decoder FSM state constants.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DOT,
    DASH,
    BOTH
  } input_state_t;

  typedef enum logic [2:0] {
    DEC_IDLE,
    DEC_MARK,
    DEC_GAP,
    DEC_LETTER,
    DEC_WORD
  } decoder_state_t;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/input_parser_if.sv
// Key-level inputs and the symbol-start strobe between the key front end and its user.
interface input_parser_if;
  logic dot;
  logic dash;
  logic out;

  modport master (output dot, output dash, input out);
  modport slave  (input dot, input dash, output out);
endinterface

// File: rtl/sync_chain.sv
// DEPTH-flop synchronizer for one asynchronous level, cleared by synchronous reset.
module sync_chain #(
  parameter int unsigned DEPTH = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/input_parser.sv
// Synchronizes dot/dash keys, tracks the held key and strobes once per new valid symbol.
// Chords lock out until both keys are released.
module input_parser
  import morse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
  input_parser_if.slave bus
);

  logic         dot_s, dash_s;
  input_state_t ps, ns;
  logic         out_q, out_d;

  sync_chain #(.DEPTH(SYNC_STAGES)) u_sync_dot (
    .Clock (Clock),
    .Reset (Reset),
    .d     (bus.dot),
    .q     (dot_s)
  );

  sync_chain #(.DEPTH(SYNC_STAGES)) u_sync_dash (
    .Clock (Clock),
    .Reset (Reset),
    .d     (bus.dash),
    .q     (dash_s)
  );

  always_comb begin
    ns = IDLE;
    unique case (ps)
      IDLE, DOT, DASH: begin
        unique case ({dot_s, dash_s})
          2'b10:   ns = DOT;
          2'b01:   ns = DASH;
          2'b11:   ns = BOTH;
          default: ns = IDLE;
        endcase
      end
      BOTH:    ns = (dot_s | dash_s) ? BOTH : IDLE;
      default: ns = IDLE;
    endcase
    out_d = ((ns == DOT) || (ns == DASH)) && (ns != ps);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ps    <= IDLE;
      out_q <= 1'b0;
    end else begin
      ps    <= ns;
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_input_parser.sv
// Directed test-plan sequences plus random key activity, checked against a behavioural model.
module tb_input_parser;
  import morse_pkg::*;

  localparam int unsigned S = 2;

  logic Clock = 1'b0;
  logic Reset;
  input_parser_if bus ();

  input_parser #(.SYNC_STAGES(S)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int passed = 0;
  int total  = 0;
  int strobes = 0;

  // Model: keys seen by the decision logic lag the raw inputs by S edges.
  // mode: 0 = no key, 1 = dot, 2 = dash, 3 = chord lockout.
  logic [1:0] pipe [S];
  int         mode = 0;
  logic       exp_out = 1'b0;

  function automatic input_state_t mode_state(input int m);
    case (m)
      1:       return DOT;
      2:       return DASH;
      3:       return BOTH;
      default: return IDLE;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic d, input logic a);
    logic [1:0] key;
    int nm;
    if (r) begin
      for (int i = 0; i < int'(S); i++) pipe[i] = 2'b00;
      mode    = 0;
      exp_out = 1'b0;
    end else begin
      key = pipe[S-1];
      if (key == 2'b00)      nm = 0;
      else if (mode == 3)    nm = 3;
      else if (key == 2'b11) nm = 3;
      else if (key == 2'b10) nm = 1;
      else                   nm = 2;
      exp_out = (nm == 1 || nm == 2) && (nm != mode);
      mode    = nm;
      for (int i = int'(S) - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = {d, a};
    end
  endtask

  task automatic cycle(input logic r, input logic d, input logic a, input string tag);
    input_state_t es;
    Reset    = r;
    bus.dot  = d;
    bus.dash = a;
    @(posedge Clock);
    model_step(r, d, a);
    #1;
    es = mode_state(mode);
    total++;
    assert (bus.out === exp_out) passed++;
    else $error("FAIL %s out: observed %b expected %b", tag, bus.out, exp_out);
    total++;
    assert (dut.ps === es) passed++;
    else $error("FAIL %s state: observed %s expected %s", tag, dut.ps.name(), es.name());
    if (bus.out === 1'b1) strobes++;
  endtask

  task automatic check_count(input string tag, input int got, input int want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s strobe count: observed %0d expected %0d", tag, got, want);
  endtask

  initial begin
    logic d, a, r;
    for (int i = 0; i < int'(S); i++) pipe[i] = 2'b00;
    Reset = 1'b1; bus.dot = 1'b0; bus.dash = 1'b0;

    // Reset with random keys, then one quiet cycle.
    cycle(1'b1, 1'($urandom), 1'($urandom), "reset");
    cycle(1'b1, 1'($urandom), 1'($urandom), "reset");
    cycle(1'b0, 1'b0, 1'b0, "post_reset");

    // Single dot.
    strobes = 0;
    cycle(1'b0, 1'b1, 1'b0, "dot");
    cycle(1'b0, 1'b1, 1'b0, "dot");
    cycle(1'b0, 1'b1, 1'b0, "dot");
    // Swap straight to dash.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, "swap");
    check_count("dot_then_swap", strobes, 2);

    // Chord, release dash only, release both, then press dash.
    strobes = 0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, "chord");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, "chord_dot_held");
    check_count("chord_lockout", strobes, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, "chord_release");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, "after_chord");
    check_count("after_chord", strobes, 1);

    // Long hold, release, re-press.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, "gap");
    strobes = 0;
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 1'b1, "long_hold");
    check_count("long_hold", strobes, 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, "idle3");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, "repress");
    check_count("repress", strobes, 2);

    // Back-to-back key swaps.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, "gap");
    strobes = 0;
    cycle(1'b0, 1'b1, 1'b0, "b2b");
    cycle(1'b0, 1'b0, 1'b1, "b2b");
    cycle(1'b0, 1'b1, 1'b0, "b2b");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, "b2b_tail");
    check_count("back_to_back", strobes, 3);

    // Reset mid-press with dot held.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, "press");
    strobes = 0;
    cycle(1'b1, 1'b1, 1'b0, "mid_reset");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, "held_after_reset");
    check_count("reset_mid_press", strobes, 1);

    // Random key activity with sticky levels and occasional reset.
    d = 1'b0; a = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) d = ~d;
      if ($urandom_range(0, 3) == 0) a = ~a;
      r = ($urandom_range(0, 59) == 0);
      cycle(r, d, a, "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/input_parser.md
# input_parser

Front-end conditioner for the Morse key inputs. It synchronizes the raw `dot` and `dash` key levels into the `Clock` domain and tracks which key is held. It emits a single-cycle `out` strobe each time a new valid symbol starts: exactly one key is newly active. It sits between the physical key inputs and the Morse decoder FSM, and rejects both-keys-pressed chords.

## Interface

- `SYNC_STAGES`, default 2: number of synchronizer flops per key input; must be at least 1.
- `Clock`  input  1  system clock; all state updates on its rising edge.
- `Reset`  input  1  synchronous, active-high reset.
- `dot`  input  1  raw dot-key level, asynchronous; 1 = pressed.
- `dash`  input  1  raw dash-key level, asynchronous; 1 = pressed.
- `out`  output  1  registered one-cycle strobe marking the start of a valid dot or dash symbol.

## Operation

- Each key passes through its own `SYNC_STAGES`-deep flop chain. The chain outputs are `dot_s` and `dash_s`. All decisions use only these synchronized levels.
- State machine, with state `ps` and next state `ns`:
  - **IDLE**
    - `dot_s & ~dash_s` → DOT
    - `~dot_s & dash_s` → DASH
    - both keys high → BOTH
    - neither key high → stay in IDLE
  - **DOT**
    - neither key high → IDLE
    - `dot_s & ~dash_s` → stay in DOT
    - `~dot_s & dash_s` → DASH (direct key change counts as a new symbol)
    - both keys high → BOTH
  - **DASH**: mirror of DOT.
    - `dot_s & ~dash_s` → DOT
    - `~dot_s & dash_s` → stay in DASH
    - neither key high → IDLE
    - both keys high → BOTH
  - **BOTH** (invalid chord, lockout): leaves only when both keys read 0, then → IDLE. A single key still held after a chord never produces a strobe.
- Strobe rule, registered: `out <= (ns == DOT || ns == DASH) && (ns != ps)`.
  - A held key yields exactly one strobe, regardless of hold length.
  - Any encoding for illegal state values decodes to IDLE on the next edge.
- The block does not report which key fired. The downstream decoder samples the synchronized levels or its own copy.

## Timing

- Reset, when `Reset` is high at a rising edge:
  - all synchronizer flops ← 0
  - state ← IDLE
  - `out` ← 0
- Reset wins over all other activity, including mid-press and during a strobe.
- After reset is released, a key still held is seen as a fresh rising level. It produces one strobe after the normal latency.
- Latency: E0 is the first edge that samples a new key level. The state and `out` update at edge E0+`SYNC_STAGES`. `out` is high for exactly the one cycle following that edge. With the default, that is the cycle after E0+2.
- Pulses shorter than one clock may be missed. There is no debounce; contact bounce longer than one cycle generates extra strobes, and upstream filtering is required if needed.
- Simultaneous transitions:
  - Both keys rising at the same edge → BOTH, no strobe.
  - A key swap at the same edge (dot 1→0, dash 0→1) → strobe for the new key.
- Back-to-back symbols (DOT→DASH→DOT each on consecutive edges) produce strobes on consecutive cycles.

## Structure

- Shared package `morse_pkg` contains the `input_state_t` enum: IDLE, DOT, DASH, BOTH. The decoder FSM's state constants belong in the same package.
- One sub-module `sync_chain`, parameterized by depth, instantiated twice (dot, dash). The state machine and strobe register live in the top module.

## Test plan

- Reset: hold `Reset` 2 cycles with random keys → `out`=0, state IDLE for both cycles and one cycle after release.
- Single dot: reset, then `dot`=1 for 3 cycles starting at edge 2 → `out`=1 only in the cycle after edge 4; 0 at all other times.
- Swap: continuing from the single-dot case, `dot`=0, `dash`=1 for 5 cycles from edge 5 → exactly one strobe, in the cycle after edge 7; state DASH.
- Chord: continuing, `dot`=1 with `dash`=1 held for 4 cycles → no strobe, state BOTH. Release `dash` only → still no strobe. Release both, then press `dash` → one strobe two edges later.
- Long hold: `dash`=1 for 50 cycles → exactly one strobe; release then re-press after 3 idle cycles → a second strobe.
- Reset mid-press: `dot` held, assert `Reset` 1 cycle during DOT → `out`=0. After release, with `dot` still held, one strobe two edges later.
